// File: rtl/fsm_cnt_test_if.sv
// Start/count request and status bundle for fsm_cnt_test.
// o_cnt exists only when FSM_CNT_STATUS_EN is defined.
interface fsm_cnt_test_if #(
    parameter int unsigned CNT_WIDTH = 7
);
    logic                 i_run;
    logic [CNT_WIDTH-1:0] i_num_cnt;
    logic                 o_idle;
    logic                 o_running;
    logic                 o_done;
`ifdef FSM_CNT_STATUS_EN
    logic [CNT_WIDTH-1:0] o_cnt;
`endif

    modport master (
        output i_run, i_num_cnt,
`ifdef FSM_CNT_STATUS_EN
        input  o_cnt,
`endif
        input  o_idle, o_running, o_done
    );

    modport slave (
        input  i_run, i_num_cnt,
`ifdef FSM_CNT_STATUS_EN
        output o_cnt,
`endif
        output o_idle, o_running, o_done
    );
endinterface

// File: rtl/fsm_cnt_test.sv
// Run-to-count controller: IDLE/RUN/DONE Moore FSM holding RUN for N cycles.
// Optional FSM_CNT_STATUS_EN exposes the internal counter as o_cnt.
module fsm_cnt_test #(
    parameter int unsigned CNT_WIDTH = 7
) (
    input  logic           clk,
    input  logic           reset,
    fsm_cnt_test_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] num_cnt_r, num_cnt_d;
    logic [CNT_WIDTH-1:0] cnt, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            num_cnt_r <= '0;
            cnt       <= '0;
        end else begin
            state_q   <= state_d;
            num_cnt_r <= num_cnt_d;
            cnt       <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        num_cnt_d = num_cnt_r;
        cnt_d     = cnt;
        case (state_q)
            IDLE: begin
                if (bus.i_run) begin
                    // A zero count skips RUN entirely
                    if (bus.i_num_cnt != '0) begin
                        num_cnt_d = bus.i_num_cnt;
                        cnt_d     = '0;
                        state_d   = RUN;
                    end else begin
                        state_d   = DONE;
                    end
                end
            end
            RUN: begin
                if (cnt == num_cnt_r - ONE) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt + ONE;
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.o_idle    = (state_q == IDLE);
    assign bus.o_running = (state_q == RUN);
    assign bus.o_done    = (state_q == DONE);
`ifdef FSM_CNT_STATUS_EN
    assign bus.o_cnt     = cnt;
`endif
endmodule

// File: tb/tb_fsm_cnt_test.sv
// Bench for fsm_cnt_test: fixed vector table, directed corner runs and
// randomized traffic checked against a queue-based schedule model.
module tb_fsm_cnt_test;
    localparam int unsigned CW = 7;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    fsm_cnt_test_if #(.CNT_WIDTH(CW)) bus ();

    fsm_cnt_test #(.CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Schedule of upcoming non-idle cycles: counter value for a RUN cycle, -1 for DONE.
    int q[$];

    task automatic model_edge(input logic r, input logic go, input logic [CW-1:0] n);
        if (r) begin
            q.delete();
        end else if (q.size() != 0) begin
            void'(q.pop_front());
        end else if (go) begin
            for (int i = 0; i < int'(n); i++) q.push_back(i);
            q.push_back(-1);
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        int exp_flags;
        int act_flags;
        act_flags = {29'd0, bus.o_idle, bus.o_running, bus.o_done};
        if (q.size() == 0)  exp_flags = 3'b100;
        else if (q[0] < 0)  exp_flags = 3'b001;
        else                exp_flags = 3'b010;
        check("model_flags{idle,run,done}", act_flags, exp_flags);
`ifdef FSM_CNT_STATUS_EN
        check("model_cnt", int'(bus.o_cnt), (q.size() != 0 && q[0] >= 0) ? q[0] : 0);
`endif
    endtask

    task automatic step(input logic r, input logic go, input logic [CW-1:0] n);
        reset         = r;
        bus.i_run     = go;
        bus.i_num_cnt = n;
        @(posedge clk);
        #1;
        model_edge(r, go, n);
        check_model();
    endtask

    // Pulse a start, then count RUN cycles (bounded) and verify the DONE/IDLE tail.
    task automatic run_width(input logic [CW-1:0] n, input int exp_last_cnt);
        int w;
        int last_cnt;
        w = 0;
        last_cnt = -1;
        step(1'b0, 1'b1, n);
        for (int k = 0; k < 400; k++) begin
            if (!bus.o_running) break;
            w++;
`ifdef FSM_CNT_STATUS_EN
            last_cnt = int'(bus.o_cnt);
`endif
            step(1'b0, 1'b0, CW'($urandom));
        end
        check($sformatf("run_width_N%0d", n), w, int'(n));
        check("done_after_run", int'(bus.o_done), 1);
        step(1'b0, 1'b0, '0);
        check("idle_after_done", int'(bus.o_idle), 1);
`ifdef FSM_CNT_STATUS_EN
        if (n != '0) check("last_cnt", last_cnt, exp_last_cnt);
`endif
    endtask

    typedef struct {
        logic          rst;
        logic          run;
        logic [CW-1:0] num;
        logic          idle;
        logic          running;
        logic          done;
        int            cnt;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int w;
        vectors     = 0;
        miscompares = 0;
        reset         = 1'b1;
        bus.i_run     = 1'b0;
        bus.i_num_cnt = '0;

        tbl[0]  = '{1'b1, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 0};
        tbl[2]  = '{1'b0, 1'b1, 7'd0, 1'b0, 1'b0, 1'b1, 0};
        tbl[3]  = '{1'b0, 1'b1, 7'd5, 1'b1, 1'b0, 1'b0, 0};
        tbl[4]  = '{1'b0, 1'b1, 7'd2, 1'b0, 1'b1, 1'b0, 0};
        tbl[5]  = '{1'b0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0, 1};
        tbl[6]  = '{1'b0, 1'b1, 7'd9, 1'b0, 1'b0, 1'b1, 0};
        tbl[7]  = '{1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 0};
        tbl[8]  = '{1'b0, 1'b1, 7'd1, 1'b0, 1'b1, 1'b0, 0};
        tbl[9]  = '{1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b1, 0};
        tbl[10] = '{1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 0};
        tbl[11] = '{1'b0, 1'b1, 7'd3, 1'b0, 1'b1, 1'b0, 0};
        tbl[12] = '{1'b1, 1'b1, 7'd4, 1'b1, 1'b0, 1'b0, 0};
        tbl[13] = '{1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 0};

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].rst, tbl[i].run, tbl[i].num);
            check($sformatf("tbl%0d_idle", i), int'(bus.o_idle), int'(tbl[i].idle));
            check($sformatf("tbl%0d_running", i), int'(bus.o_running), int'(tbl[i].running));
            check($sformatf("tbl%0d_done", i), int'(bus.o_done), int'(tbl[i].done));
`ifdef FSM_CNT_STATUS_EN
            check($sformatf("tbl%0d_cnt", i), int'(bus.o_cnt), tbl[i].cnt);
`endif
        end

        run_width(7'd100, 99);
        run_width(7'd1, 0);
        run_width(7'd127, 126);
        run_width(7'd0, 0);

        // Mid-run start request with a different count must be ignored
        w = 0;
        step(1'b0, 1'b1, 7'd10);
        for (int k = 0; k < 40; k++) begin
            if (!bus.o_running) break;
            w++;
            if (k == 3) step(1'b0, 1'b1, 7'd5);
            else        step(1'b0, 1'b0, 7'd5);
        end
        check("ignored_retrigger_width", w, 10);
        step(1'b0, 1'b0, '0);

        // Reset during RUN cycle 40 aborts without DONE
        step(1'b0, 1'b1, 7'd100);
        for (int k = 0; k < 39; k++) step(1'b0, 1'b0, '0);
        check("abort_still_running", int'(bus.o_running), 1);
        step(1'b1, 1'b0, '0);
        check("abort_idle", int'(bus.o_idle), 1);
        w = 0;
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, '0);
            w += int'(bus.o_done);
        end
        check("abort_no_done", w, 0);
        run_width(7'd3, 2);

        // i_run held high straight through DONE into IDLE
        for (int k = 0; k < 12; k++) step(1'b0, 1'b1, 7'd2);

        for (int k = 0; k < 3000; k++) begin
            logic [CW-1:0] n;
            n = ($urandom_range(0, 9) == 0) ? CW'($urandom) : CW'($urandom_range(0, 12));
            step(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) == 0), n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
